// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one external multiplier among requesters.
// Each job: grant, flush multiplier, run to result or timeout, hold response.
module mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = 8,
  parameter int B_W     = 4,
  parameter int TIMEOUT = 32,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int C_W    = A_W + (1 << B_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_vld,
  output logic [NUM_REQ-1:0]     req_rdy,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [ID_W-1:0]        rsp_id,
  output logic [C_W-1:0]         rsp_c,
  output logic                   rsp_err,
  output logic                   mul_rst_n,
  output logic                   mul_vld,
  output logic [A_W-1:0]         mul_a,
  output logic [B_W-1:0]         mul_b,
  input  logic [C_W-1:0]         mul_c,
  input  logic                   mul_result_vld,
  output logic                   busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_BUSY,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [C_W-1:0]   rsp_c_q, rsp_c_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt_any;
  logic [ID_W-1:0]  gnt_idx;
  logic [ID_W-1:0]  sel;
  logic             run;

  assign run = !rst;

  // First valid requester at or after ptr, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any && req_vld[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    rsp_c_d   = rsp_c_q;
    rsp_err_d = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          id_d    = gnt_idx;
          a_d     = req_a[gnt_idx*A_W +: A_W];
          b_d     = req_b[gnt_idx*B_W +: B_W];
          ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1))
                    ? '0 : gnt_idx + 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (mul_result_vld) begin
          rsp_c_d   = mul_c;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_c_d   = '0;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      rsp_c_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      rsp_c_q   <= rsp_c_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Outputs forced to reset values for as long as rst is held
  assign req_rdy   = (run && state_q == S_IDLE && gnt_any)
                     ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign busy      = run && (state_q != S_IDLE);
  assign mul_rst_n = run && (state_q != S_CLEAR);
  assign mul_vld   = run && (state_q == S_BUSY);
  assign mul_a     = busy ? a_q : '0;
  assign mul_b     = busy ? b_q : '0;
  assign rsp_vld   = run && (state_q == S_RESP);
  assign rsp_id    = run ? id_q : '0;
  assign rsp_c     = run ? rsp_c_q : '0;
  assign rsp_err   = run && rsp_err_q;

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter A_W, default 8: operand A width.
REQ-003 SHALL have parameter B_W, default 4: operand B width.
REQ-004 SHALL have parameter TIMEOUT, default 32: max BUSY cycles before error.
REQ-005 SHALL have port clk  in  1: single clock, all logic on posedge.
REQ-006 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-007 SHALL have port req_vld  in  NUM_REQ: per-requester request valid.
REQ-008 SHALL have port req_rdy  out  NUM_REQ: per-requester accept, one-hot or zero.
REQ-009 SHALL have port req_a  in  NUM_REQ*A_W: packed operand A, requester i at slice i.
REQ-010 SHALL have port req_b  in  NUM_REQ*B_W: packed operand B, requester i at slice i.
REQ-011 SHALL have port rsp_vld  out  1: response valid.
REQ-012 SHALL have port rsp_rdy  in  1: response consumer ready.
REQ-013 SHALL have port rsp_id  out  $clog2(NUM_REQ): index of the served requester.
REQ-014 SHALL have port rsp_c  out  C_W = A_W+(1<<B_W): product.
REQ-015 SHALL have port rsp_err  out  1: timeout flag.
REQ-016 SHALL have port mul_rst_n  out  1: active-low reset to the shared multiplier.
REQ-017 SHALL have port mul_vld  out  1: multiplier operand valid.
REQ-018 SHALL have port mul_a  out  A_W: multiplier operand A.
REQ-019 SHALL have port mul_b  out  B_W: multiplier operand B.
REQ-020 SHALL have port mul_c  in  C_W: multiplier result.
REQ-021 SHALL have port mul_result_vld  in  1: multiplier result strobe.
REQ-022 SHALL have port busy  out  1: high whenever state is not IDLE.

Function
REQ-023 SHALL implement the FSM IDLE -> CLEAR -> BUSY -> RESP -> IDLE.
REQ-024 IDLE: if any req_vld is high, SHALL assert req_rdy for exactly one granted index, latch its operands and index, and move to CLEAR next cycle.
REQ-025 SHALL arbitrate round-robin: grant the first req_vld at or after pointer ptr, wrapping modulo NUM_REQ; on grant, ptr <= grant+1 (mod NUM_REQ).
REQ-026 req_rdy SHALL be zero in every state except IDLE; a request is accepted only on req_vld&req_rdy.
REQ-027 CLEAR: SHALL drive mul_rst_n=0 for exactly one cycle to flush the multiplier accumulator and counter, then move to BUSY.
REQ-028 BUSY: SHALL drive mul_vld=1 with mul_a/mul_b held at the latched operands every cycle until exit.
REQ-029 BUSY: on mul_result_vld=1, SHALL capture mul_c into rsp_c, set rsp_err=0 and move to RESP.
REQ-030 BUSY: SHALL count cycles from 0; if the count reaches TIMEOUT-1 without mul_result_vld, SHALL set rsp_c=0, rsp_err=1 and move to RESP; mul_result_vld in that same cycle SHALL win.
REQ-031 mul_vld SHALL be 0 outside BUSY; mul_a/mul_b SHALL be 0 in IDLE.
REQ-032 RESP: rsp_vld=1 with rsp_id/rsp_c/rsp_err stable until rsp_rdy=1; on handshake, SHALL move to IDLE. No grant occurs in the handshake cycle.
REQ-033 mul_result_vld outside BUSY SHALL be ignored.
REQ-034 Requesters dropping req_vld in non-IDLE states SHALL have no effect.

Reset
REQ-035 While rst=1: SHALL set state=IDLE, ptr=0, BUSY counter=0, rsp_vld=0, rsp_c=0, rsp_id=0, rsp_err=0, req_rdy=0, mul_vld=0, busy=0, and drive mul_rst_n=0.
REQ-036 rst asserted in any state mid-operation SHALL abort the operation with no response produced; after release the first grant goes to the lowest-indexed valid requester.

Verification
REQ-037 Single request, shared shift multiplier attached: req 2, a=3, b=5 at cycle 0 -> req_rdy[2]=1 at cycle 0, mul_rst_n=0 at cycle 1, mul_vld=1 from cycle 2, mul_result_vld at cycle 7, rsp_vld at cycle 8 with rsp_id=2, rsp_c=15, rsp_err=0.
REQ-038 All four req_vld held high continuously, rsp_rdy=1 -> grants in order 0,1,2,3,0; no requester granted twice before all others are served.
REQ-039 Back-to-back: a=3, b=5 then a=2, b=1 from req 0 -> second rsp_c=2, proving CLEAR flushed the accumulator.
REQ-040 mul_result_vld tied 0 -> rsp_vld after exactly 32 BUSY cycles, rsp_err=1, rsp_c=0.
REQ-041 Backpressure: rsp_rdy=0 for 10 cycles in RESP -> rsp_vld, rsp_id, rsp_c stable; req_rdy=0 throughout; IDLE the cycle after rsp_rdy=1.
REQ-042 rst=1 during BUSY -> next cycle all outputs at reset values, mul_rst_n=0, no rsp_vld after release.
